// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL reset/lock sequencer.
//   seq_state_t  sequencer states
//   CNT_SAT      saturation value of the 8-bit event counters
//   cnt_width()  width of the shared cycle counter
//   sat_inc()    saturating increment for the 8-bit event counters
package pll_seq_pkg;

  typedef enum logic [1:0] {
    S_PLLRST   = 2'd0,
    S_WAITLOCK = 2'd1,
    S_RELEASE  = 2'd2,
    S_RUN      = 2'd3
  } seq_state_t;

  localparam logic [7:0] CNT_SAT = 8'hFF;

  // Wide enough to hold the largest terminal count of any phase.
  function automatic int cnt_width(input int pll_rst_cycles, input int lock_filter,
                                   input int release_span, input int lock_timeout);
    int m;
    m = pll_rst_cycles;
    if (lock_filter  > m) m = lock_filter;
    if (release_span > m) m = release_span;
    if (lock_timeout > m) m = lock_timeout;
    return $clog2(m + 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL-facing and downstream-facing signals of the sequencer.
//   pll_locked       PLL lock indication (asynchronous to refclk)
//   pll_rst          active-high PLL reset
//   chan_rst         active-high per-domain resets, bit 0 released first
//   ready            all domains released and lock stable
//   lock_loss_count  saturating count of lock-loss events
//   retry_count      saturating count of watchdog PLL re-resets
// master: sequencer side; slave: PLL wrapper / consumer side.
interface pll_reset_sequencer_if #(
  parameter int NUM_CHANNELS = 3
);
  logic                    pll_locked;
  logic                    pll_rst;
  logic [NUM_CHANNELS-1:0] chan_rst;
  logic                    ready;
  logic [7:0]              lock_loss_count;
  logic [7:0]              retry_count;

  modport master (
    input  pll_locked,
    output pll_rst, chan_rst, ready, lock_loss_count, retry_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, chan_rst, ready, lock_loss_count, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// pll_lock_sync: STAGES-deep single-bit synchroniser, cleared asynchronously by rst.
//   clk  destination clock
//   rst  asynchronous active-high clear
//   d    asynchronous input
//   q    synchronised output (d delayed by STAGES rising edges)
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL in reset, filters its lock indication, releases
// NUM_CHANNELS reset domains STAGGER cycles apart, then asserts ready. Loss of lock
// re-asserts every channel reset, counts the event and re-runs the lock filter
// (the PLL itself is not re-reset).
//   refclk  free-running reference clock, rising edge
//   rst     asynchronous active-high reset
//   bus     pll_reset_sequencer_if.master (pll_locked in; pll_rst, chan_rst, ready,
//           lock_loss_count, retry_count out)
// Optional: define PLL_LOCK_WATCHDOG_EN to add a lock-acquisition watchdog that
// re-resets the PLL after LOCK_TIMEOUT cycles in S_WAITLOCK and counts retries.
// Without it retry_count is tied to 0.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CHANNELS   = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_FILTER    = 1024,
  parameter int STAGGER        = 16,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input logic                    refclk,
  input logic                    rst,
  pll_reset_sequencer_if.master  bus
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_FILTER,
                                (NUM_CHANNELS-1)*STAGGER + 1, LOCK_TIMEOUT);
  localparam logic [CW-1:0] PR_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LF_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] REL_LAST = CW'((NUM_CHANNELS-1)*STAGGER);

  seq_state_t              state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [7:0]              loss_q, loss_nxt;
  logic                    locked_s;
  logic                    pll_rst_q, pll_rst_nxt;
  logic [NUM_CHANNELS-1:0] chan_q, chan_nxt;
  logic                    ready_q, ready_nxt;

`ifdef PLL_LOCK_WATCHDOG_EN
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
  logic [CW-1:0]           wd, wd_nxt;
  logic [7:0]              retry_q, retry_nxt;
`endif

  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_nxt  = loss_q;
`ifdef PLL_LOCK_WATCHDOG_EN
    retry_nxt = retry_q;
    wd_nxt    = '0;
`endif
    case (state)
      S_PLLRST: begin
        if (cnt == PR_LAST) begin
          state_nxt = S_WAITLOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_WAITLOCK: begin
        // Any low sample restarts the filter, however short the dropout.
        if (!locked_s) begin
          cnt_nxt = '0;
        end else if (cnt == LF_LAST) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        // Lock loss takes priority over a release step or S_RUN entry.
        if (!locked_s) begin
          state_nxt = S_WAITLOCK;
          cnt_nxt   = '0;
          loss_nxt  = sat_inc(loss_q);
        end else if (state == S_RELEASE) begin
          if (cnt == REL_LAST) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = S_PLLRST;
        cnt_nxt   = '0;
      end
    endcase

`ifdef PLL_LOCK_WATCHDOG_EN
    // Runs only while staying in S_WAITLOCK; a filter completion in the same
    // cycle as the timeout wins, so a good lock is never thrown away.
    if (state == S_WAITLOCK && state_nxt == S_WAITLOCK) begin
      if (wd == TO_LAST) begin
        state_nxt = S_PLLRST;
        cnt_nxt   = '0;
        retry_nxt = sat_inc(retry_q);
      end else begin
        wd_nxt = wd + CW'(1);
      end
    end
`endif

    // Outputs are decoded from the next state and registered, so they are
    // glitch-free yet change on the same edge as the state.
    pll_rst_nxt = (state_nxt == S_PLLRST);
    ready_nxt   = (state_nxt == S_RUN);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (state_nxt == S_RUN)          chan_nxt[i] = 1'b0;
      else if (state_nxt == S_RELEASE) chan_nxt[i] = (cnt_nxt < CW'(i*STAGGER));
      else                             chan_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_PLLRST;
      cnt       <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      chan_q    <= '1;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      loss_q    <= loss_nxt;
      pll_rst_q <= pll_rst_nxt;
      chan_q    <= chan_nxt;
      ready_q   <= ready_nxt;
    end
  end

`ifdef PLL_LOCK_WATCHDOG_EN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      wd      <= '0;
      retry_q <= '0;
    end else begin
      wd      <= wd_nxt;
      retry_q <= retry_nxt;
    end
  end
  assign bus.retry_count = retry_q;
`else
  assign bus.retry_count = '0;
`endif

  assign bus.pll_rst         = pll_rst_q;
  assign bus.chan_rst        = chan_q;
  assign bus.ready           = ready_q;
  assign bus.lock_loss_count = loss_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: bench for pll_reset_sequencer with shortened filter/stagger.
// Hand-derived vector table, hand sequences for glitch / saturation / async reset,
// then randomised lock patterns against a streak-based reference model.
module tb_pll_reset_sequencer;
  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int PR   = 8;
  localparam int LF   = 20;
  localparam int ST   = 5;
  localparam int LT   = 100;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  always #5 refclk = ~refclk;

  pll_reset_sequencer_if #(.NUM_CHANNELS(N)) bus();

  pll_reset_sequencer #(
    .NUM_CHANNELS(N), .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PR),
    .LOCK_FILTER(LF), .STAGGER(ST), .LOCK_TIMEOUT(LT)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the sequencer position follows from how many PLL-reset
  // edges have elapsed and the length of the current run of synced-high lock
  // samples. k = streak - LF is the number of edges since release began.
  int m_boot, m_streak, m_loss, m_retry;
  bit m_dly[$];
`ifdef PLL_LOCK_WATCHDOG_EN
  int m_wait;
`endif

  task automatic m_reset();
    m_boot = 0; m_streak = 0; m_loss = 0; m_retry = 0;
    m_dly = {};
    for (int i = 0; i < SYNC; i++) m_dly.push_back(1'b0);
`ifdef PLL_LOCK_WATCHDOG_EN
    m_wait = 0;
`endif
  endtask

  task automatic m_edge();
    bit ls;
    ls = m_dly.pop_front();
    m_dly.push_back(bus.pll_locked);
    if (m_boot < PR) begin
      m_boot++;
      m_streak = 0;
`ifdef PLL_LOCK_WATCHDOG_EN
      m_wait = 0;
`endif
    end else if (m_streak < LF) begin
      if (ls) m_streak++; else m_streak = 0;
`ifdef PLL_LOCK_WATCHDOG_EN
      if (m_streak >= LF) m_wait = 0;
      else if (m_wait == LT-1) begin
        m_boot = 0; m_streak = 0; m_wait = 0;
        if (m_retry < 255) m_retry++;
      end else m_wait++;
`endif
    end else begin
      if (ls) m_streak++;
      else begin
        m_streak = 0;
        if (m_loss < 255) m_loss++;
`ifdef PLL_LOCK_WATCHDOG_EN
        m_wait = 0;
`endif
      end
    end
  endtask

  task automatic model_check();
    logic [N-1:0] ec;
    bit           er;
    int           k;
    ec = '1;
    er = 1'b0;
    if (m_boot >= PR && m_streak >= LF) begin
      k = m_streak - LF;
      for (int i = 0; i < N; i++) ec[i] = (k < i*ST);
      er = (k > (N-1)*ST);
    end
    check("m_pll_rst", 32'(bus.pll_rst),         32'(m_boot < PR));
    check("m_chan",    32'(bus.chan_rst),        32'(ec));
    check("m_ready",   32'(bus.ready),           32'(er));
    check("m_loss",    32'(bus.lock_loss_count), 32'(m_loss));
    check("m_retry",   32'(bus.retry_count),     32'(m_retry));
  endtask

  // Drive at the falling edge, let one rising edge happen, compare at the next falling edge.
  task automatic step(input bit lk);
    bus.pll_locked = lk;
    @(posedge refclk);
    m_edge();
    @(negedge refclk);
    model_check();
  endtask

  // Called at a falling edge: asserts rst between clock edges and checks that
  // every output has already returned to its reset value.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_pll_rst", 32'(bus.pll_rst),         32'd1);
    check("rst_chan",    32'(bus.chan_rst),        32'(3'b111));
    check("rst_ready",   32'(bus.ready),           32'd0);
    check("rst_loss",    32'(bus.lock_loss_count), 32'd0);
    check("rst_retry",   32'(bus.retry_count),     32'd0);
    m_reset();
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int           cycles;
    bit           locked;
    bit           pll_rst;
    bit [N-1:0]   chan;
    bit           ready;
    int           loss;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int  n;
    bit  fell;
    int  cyc;
    bit  lv;
    int  len;

    vecs = '{
      '{0,  1'b0, 1'b1, 3'b111, 1'b0, 0},  // reset state
      '{7,  1'b0, 1'b1, 3'b111, 1'b0, 0},  // still in PLL reset
      '{1,  1'b0, 1'b0, 3'b111, 1'b0, 0},  // 8th edge ends PLL reset
      '{50, 1'b0, 1'b0, 3'b111, 1'b0, 0},  // no lock: waits
      '{21, 1'b1, 1'b0, 3'b111, 1'b0, 0},  // one edge short of release
      '{1,  1'b1, 1'b0, 3'b110, 1'b0, 0},  // SYNC+LF edges: ch0 released
      '{4,  1'b1, 1'b0, 3'b110, 1'b0, 0},
      '{1,  1'b1, 1'b0, 3'b100, 1'b0, 0},  // ch1 STAGGER later
      '{5,  1'b1, 1'b0, 3'b000, 1'b0, 0},  // ch2 another STAGGER later
      '{1,  1'b1, 1'b0, 3'b000, 1'b1, 0},  // ready one edge after ch2
      '{10, 1'b1, 1'b0, 3'b000, 1'b1, 0},
      '{2,  1'b0, 1'b0, 3'b000, 1'b1, 0},  // drop still in synchroniser
      '{1,  1'b0, 1'b0, 3'b111, 1'b0, 1},  // lock loss seen
      '{2,  1'b0, 1'b0, 3'b111, 1'b0, 1},
      '{21, 1'b1, 1'b0, 3'b111, 1'b0, 1},
      '{1,  1'b1, 1'b0, 3'b110, 1'b0, 1},  // same re-release timing
      '{15, 1'b1, 1'b0, 3'b000, 1'b1, 1}
    };

    bus.pll_locked = 1'b0;
    @(negedge refclk);
    do_reset();

    for (int v = 0; v < 17; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].locked);
      check($sformatf("vec%0d_pll_rst", v), 32'(bus.pll_rst),         32'(vecs[v].pll_rst));
      check($sformatf("vec%0d_chan", v),    32'(bus.chan_rst),        32'(vecs[v].chan));
      check($sformatf("vec%0d_ready", v),   32'(bus.ready),           32'(vecs[v].ready));
      check($sformatf("vec%0d_loss", v),    32'(bus.lock_loss_count), 32'(vecs[v].loss));
    end

    // One-cycle dropout mid-filter restarts the count from zero.
    do_reset();
    repeat (PR) step(1'b0);
    repeat (12) step(1'b1);
    step(1'b0);
    n = 0;
    fell = 1'b0;
    while (!fell && n < 200) begin
      step(1'b1);
      n++;
      if (bus.chan_rst[0] == 1'b0) fell = 1'b1;
    end
    check("glitch_release_edges", 32'(n), 32'(SYNC + LF));

    // 300 lock-loss events: counter saturates.
    do_reset();
    repeat (PR) step(1'b0);
    repeat (300) begin
      repeat (SYNC + LF) step(1'b1);
      repeat (3) step(1'b0);
    end
    check("loss_saturated", 32'(bus.lock_loss_count), 32'd255);
    check("loss_sat_chan",  32'(bus.chan_rst),        32'(3'b111));

    // Async reset in the middle of the release phase (after one loss).
    do_reset();
    repeat (PR) step(1'b0);
    repeat (SYNC + LF) step(1'b1);
    repeat (3) step(1'b0);
    repeat (SYNC + LF + 3) step(1'b1);
    check("midrel_chan", 32'(bus.chan_rst),        32'(3'b110));
    check("midrel_loss", 32'(bus.lock_loss_count), 32'd1);
    do_reset();

`ifdef PLL_LOCK_WATCHDOG_EN
    repeat (PR + LT) step(1'b0);
    check("wd_repulse_pll_rst", 32'(bus.pll_rst),     32'd1);
    check("wd_repulse_retry",   32'(bus.retry_count), 32'd1);
    repeat (PR) step(1'b0);
    check("wd_repulse_end",     32'(bus.pll_rst),     32'd0);
    do_reset();
`endif

    // Random lock patterns, with occasional async resets.
    cyc = 0;
    while (cyc < 4000) begin
      lv  = ($urandom_range(0, 3) != 0);
      len = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 8));
      repeat (len) step(lv);
      cyc += len;
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
